inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 99 +++++++++
 tb/tb_inst_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives a combinational instruction ROM and buffers fetched
// {pc, inst} pairs in a 2-entry queue that feeds decode.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        ce,
   output logic [31:0] pc,
   input  logic [31:0] inst_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o,
   input  logic        id_ready_i
);

   logic        r_ce;
   logic [31:0] r_pc;
   logic [1:0]  r_cnt;
   logic [31:0] r_pc0;
   logic [31:0] r_inst0;
   logic [31:0] r_pc1;
   logic [31:0] r_inst1;

   logic        w_valid;
   logic        w_full;
   logic        w_deq;
   logic        w_branch;
   logic        w_fetch;

   assign w_valid  = (r_cnt != 2'd0);
   assign w_full   = (r_cnt == 2'(QDEPTH));
   assign w_deq    = w_valid & id_ready_i;
   assign w_branch = r_ce & branch_flag_i;
   assign w_fetch  = r_ce & ~stall_i & ~branch_flag_i & (~w_full | w_deq);

   // Slot 0 is always the queue head; slot 1 holds the younger entry when two are queued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ce    <= 1'b0;
         r_pc    <= RESET_PC & 32'hFFFF_FFFC;
         r_cnt   <= 2'd0;
         r_pc0   <= 32'd0;
         r_inst0 <= 32'd0;
         r_pc1   <= 32'd0;
         r_inst1 <= 32'd0;
      end else begin
         r_ce <= 1'b1;
         if (w_branch) begin
            r_cnt <= 2'd0;
            r_pc  <= branch_target_i & 32'hFFFF_FFFC;
         end else begin
            if (w_fetch) begin
               r_pc <= r_pc + 32'd4;
            end
            case ({w_fetch, w_deq})
               2'b11: begin
                  if (r_cnt == 2'd2) begin
                     r_pc0   <= r_pc1;
                     r_inst0 <= r_inst1;
                     r_pc1   <= r_pc;
                     r_inst1 <= inst_i;
                  end else begin
                     r_pc0   <= r_pc;
                     r_inst0 <= inst_i;
                  end
               end
               2'b01: begin
                  r_pc0   <= r_pc1;
                  r_inst0 <= r_inst1;
                  r_cnt   <= r_cnt - 2'd1;
               end
               2'b10: begin
                  if (r_cnt == 2'd0) begin
                     r_pc0   <= r_pc;
                     r_inst0 <= inst_i;
                  end else begin
                     r_pc1   <= r_pc;
                     r_inst1 <= inst_i;
                  end
                  r_cnt <= r_cnt + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign ce         = r_ce;
   assign pc         = r_pc;
   assign id_valid_o = w_valid;
   assign id_pc_o    = w_valid ? r_pc0 : 32'd0;
   assign id_inst_o  = w_valid ? r_inst0 : 32'd0;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic, all cycles compared against
// a queue-based reference model of the fetch stage.
module tb_inst_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        ce;
   logic [31:0] pc;
   logic [31:0] inst_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_valid_o;
   logic        id_ready_i;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   logic        m_ce;
   logic [31:0] m_pc;
   logic [63:0] m_q[$];

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   always #5 clk = ~clk;

   assign inst_i = ce ? rom(pc) : 32'h0;

   inst_fetch #(
      .RESET_PC(RST_PC),
      .QDEPTH  (2)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .branch_flag_i  (branch_flag_i),
      .branch_target_i(branch_target_i),
      .ce             (ce),
      .pc             (pc),
      .inst_i         (inst_i),
      .id_pc_o        (id_pc_o),
      .id_inst_o      (id_inst_o),
      .id_valid_o     (id_valid_o),
      .id_ready_i     (id_ready_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, compare outputs with the model, then advance the model.
   task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic rdy);
      logic [63:0] h;
      logic        deq;
      logic        fetch;
      rst             = r;
      stall_i         = s;
      branch_flag_i   = b;
      branch_target_i = t;
      id_ready_i      = rdy;
      #1;
      if (chk_en) begin
         h = (m_q.size() != 0) ? m_q[0] : 64'h0;
         check("ce", {31'b0, ce}, {31'b0, m_ce});
         check("pc", pc, m_pc);
         check("id_valid", {31'b0, id_valid_o}, {31'b0, m_q.size() != 0});
         check("id_pc", id_pc_o, h[63:32]);
         check("id_inst", id_inst_o, h[31:0]);
      end
      @(posedge clk);
      if (!r) begin
         m_ce = 1'b0;
         m_pc = RST_PC;
         m_q.delete();
      end else begin
         deq = (m_q.size() != 0) && rdy;
         if (m_ce && b) begin
            m_q.delete();
            m_pc = {t[31:2], 2'b00};
         end else begin
            fetch = m_ce && !s && ((m_q.size() < 2) || deq);
            if (deq) void'(m_q.pop_front());
            if (fetch) begin
               m_q.push_back({m_pc, rom(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
         m_ce = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0; stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0; id_ready_i = 1'b0;
      m_ce = 1'b0; m_pc = RST_PC;
      @(negedge clk);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk_en = 1'b1;
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // Reset release with decode always ready: one instruction per cycle
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s1_empty", {31'b0, id_valid_o}, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         check("s1_id_pc", id_pc_o, 32'(4 * k));
         check("s1_id_inst", id_inst_o, 32'h1000_0000 + 32'(k));
         step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      end

      // Decode not ready after release: queue fills and pc holds
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("s2_pc_held", pc, 32'h8);
      check("s2_valid", {31'b0, id_valid_o}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         check("s2_order", id_pc_o, 32'(4 * k));
         step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      end

      // Branch with a full queue
      step(1'b1, 1'b0, 1'b1, 32'h0000_0043, 1'b0);
      check("s3_flush", {31'b0, id_valid_o}, 32'd0);
      check("s3_pc", pc, 32'h40);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("s3_id_pc", id_pc_o, 32'h40);

      // Stall with decode ready: queue drains, pc frozen, resume at frozen pc
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      check("s4_drained", {31'b0, id_valid_o}, 32'd0);
      check("s4_pc_frozen", pc, 32'h48);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s4_resume", id_pc_o, 32'h48);
      check("s4_pc_adv", pc, 32'h4c);

      // Wrap of pc through 2^32
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      check("s5_pc0", pc, 32'hFFFF_FFF8);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s5_pc1", pc, 32'hFFFF_FFFC);
      check("s5_id1", id_pc_o, 32'hFFFF_FFF8);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s5_pc2", pc, 32'h0);
      check("s5_id2", id_pc_o, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s5_id3", id_pc_o, 32'h0);

      // Reset while full and branching
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check("s6_full", {31'b0, id_valid_o}, 32'd1);
      step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1);
      check("s6_ce", {31'b0, ce}, 32'd0);
      check("s6_pc", pc, RST_PC);
      check("s6_valid", {31'b0, id_valid_o}, 32'd0);
      check("s6_id_pc", id_pc_o, 32'd0);
      check("s6_id_inst", id_inst_o, 32'd0);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
